pipe_ctrl: RTL and testbench

Pipeline stall/flush controller for the 5-stage MIPS core. It merges hazard stall requests from ID, EXE and MEM into the 6-bit `stall` vector consumed by `pc`, `if_id`, `id_exe`, `exe_mem` and `mem_wb`. It sequences exception flushes through a small FSM that waits out outstanding data-memory stalls, and it optionally keeps stall/flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 33 +++
 rtl/pipe_ctrl_perf_cnt.sv | 32 +++
 rtl/pipe_ctrl.sv | 132 +++++++++++++
 tb/tb_pipe_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline stall/flush controller. This package
// holds the stall codes consumed by pc/if_id/id_exe/exe_mem/mem_wb, the
// controller FSM state encoding, and the stall priority-merge helper.
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  // Stall codes. Bit0 pc, bit1 if_id, bit2 id_exe, bit3 exe_mem, bit4 mem_wb,
  // bit5 reserved (always 0). A wider code freezes more stages.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EXE  = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_REFILL   = 2'd3
  } state_e;

  // When several hazards are active, the widest code wins (MEM > EXE > ID).
  function automatic logic [5:0] merge_stall(input logic req_id,
                                             input logic req_exe,
                                             input logic req_mem);
    if (req_mem)      return STALL_MEM;
    else if (req_exe) return STALL_EXE;
    else if (req_id)  return STALL_ID;
    else              return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// -----------------------------------------------------------------------------
// pipe_perf_cnt
// Saturating up-counter with an increment enable; used for the stall/flush
// performance counters of pipe_ctrl.
// Ports:
//   clk   in  1 : clock, counts on the rising edge
//   reset in  1 : asynchronous active-high reset, clears the count
//   en    in  1 : increment this cycle
//   count out W : current count, sticks at all-ones
// -----------------------------------------------------------------------------
module pipe_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = W'(1);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Pipeline stall/flush controller for the 5-stage MIPS core. Merges hazard
// stall requests from ID/EXE/MEM into the 6-bit stall vector and sequences
// exception flushes (IDLE -> [WAIT_MEM] -> FLUSH -> REFILL -> IDLE).
//
// Optional feature: define PIPE_CTRL_PERF_EN to build the saturating
// stall-cycle and flush counters; otherwise both counter ports read 0.
//
// Ports:
//   clk          in  1     : core clock
//   reset        in  1     : asynchronous active-high reset
//   stallreq_id  in  1     : load-use hazard in ID
//   stallreq_exe in  1     : multi-cycle EXE op busy
//   stallreq_mem in  1     : data memory not ready
//   excp_req     in  1     : exception raised by the MEM instruction (level)
//   excp_vector  in  VEC_W : handler address, valid with excp_req
//   stall        out 6     : per-stage stall (combinational)
//   flush        out 1     : clear all pipeline registers (registered)
//   flush_pc     out VEC_W : next PC, valid while flush is 1
//   busy         out 1     : FSM not in IDLE
//   stall_cycles out CNT_W : cycles with stall != 0 (perf build only)
//   flush_count  out CNT_W : flushes issued (perf build only)
// -----------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int VEC_W = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stallreq_id,
  input  logic             stallreq_exe,
  input  logic             stallreq_mem,
  input  logic             excp_req,
  input  logic [VEC_W-1:0] excp_vector,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [VEC_W-1:0] flush_pc,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  state_e           state;
  state_e           next_state;
  logic [5:0]       stall_c;
  logic [VEC_W-1:0] vec_q;
  logic             flush_q;

  // Next-state and stall decode. stall is zero-latency from the requests so
  // the stage registers see it before the same clock edge.
  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    next_state = state;
    stall_c    = STALL_NONE;
    unique case (state)
      ST_IDLE: begin
        stall_c = merge_stall(stallreq_id, stallreq_exe, stallreq_mem);
        if (excp_req) begin
          // Hold at least EXE so younger instructions cannot advance past
          // the faulting one while the flush is being arranged.
          if (!stallreq_mem) stall_c = STALL_EXE;
          next_state = stallreq_mem ? ST_WAIT_MEM : ST_FLUSH;
        end
      end
      ST_WAIT_MEM: begin
        // ID/EXE requests are irrelevant: everything younger is flushed.
        stall_c = stallreq_mem ? STALL_MEM : STALL_EXE;
        if (!stallreq_mem) next_state = ST_FLUSH;
      end
      ST_FLUSH: begin
        stall_c    = STALL_NONE;
        next_state = ST_REFILL;
      end
      ST_REFILL: begin
        // Pipeline holds only bubbles, so ID/EXE hazards are spurious; the
        // still-high excp_req from the requester is absorbed here.
        stall_c    = stallreq_mem ? STALL_MEM : STALL_NONE;
        next_state = ST_IDLE;
      end
      default: begin
        stall_c    = STALL_NONE;
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      vec_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state   <= next_state;
      flush_q <= (next_state == ST_FLUSH);
      // Capture only in IDLE; later vector changes must not redirect the PC.
      if ((state == ST_IDLE) && excp_req) vec_q <= excp_vector;
    end
  end

  // Reset forces stall low even though it is combinational from the requests.
  assign stall    = reset ? STALL_NONE : stall_c;
  assign flush    = flush_q;
  assign flush_pc = flush_q ? vec_q : '0;
  assign busy     = (state != ST_IDLE);

`ifdef PIPE_CTRL_PERF_EN
  logic flush_entry;
  assign flush_entry = (next_state == ST_FLUSH) && (state != ST_FLUSH);

  pipe_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (stall != STALL_NONE),
    .count (stall_cycles)
  );

  pipe_perf_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (flush_entry),
    .count (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl: table of IDLE stall-merge vectors plus
// hand-written exception, MEM-wait, REFILL-masking, reset-abort and counter
// sequences. Counters are 4 bits wide here so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int VEC_W = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             stallreq_id;
  logic             stallreq_exe;
  logic             stallreq_mem;
  logic             excp_req;
  logic [VEC_W-1:0] excp_vector;
  logic [5:0]       stall;
  logic             flush;
  logic [VEC_W-1:0] flush_pc;
  logic             busy;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.VEC_W(VEC_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .stallreq_id  (stallreq_id),
    .stallreq_exe (stallreq_exe),
    .stallreq_mem (stallreq_mem),
    .excp_req     (excp_req),
    .excp_vector  (excp_vector),
    .stall        (stall),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .busy         (busy),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       id;
    logic       exe;
    logic       mem;
    logic [5:0] exp_stall;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance to the drive point just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    stallreq_id  = 1'b0;
    stallreq_exe = 1'b0;
    stallreq_mem = 1'b0;
    excp_req     = 1'b0;
  endtask

  // Exception with no MEM stall; requester drops excp_req after seeing flush.
  task automatic do_excp(input logic [VEC_W-1:0] v);
    excp_req    = 1'b1;
    excp_vector = v;
    tick();          // now FLUSH
    tick();          // now REFILL
    excp_req = 1'b0;
    tick();          // now IDLE
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 6'b000000};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 6'b000111};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 6'b001111};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 6'b001111};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 6'b011111};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 6'b011111};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 6'b011111};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 6'b011111};

    // ---- reset state, with requests active to show outputs are forced ----
    reset        = 1'b1;
    stallreq_id  = 1'b1;
    stallreq_exe = 1'b1;
    stallreq_mem = 1'b1;
    excp_req     = 1'b1;
    excp_vector  = 32'h1234_5678;
    sample();
    check("reset_stall", stall, 6'b000000);
    check("reset_flush", flush, 1'b0);
    check("reset_flush_pc", flush_pc, 32'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_stall_cycles", stall_cycles, 4'd0);
    check("reset_flush_count", flush_count, 4'd0);
    clear_inputs();
    tick();
    reset = 1'b0;
    tick();

    // ---- IDLE priority merge table ----
    for (int i = 0; i < 8; i++) begin
      stallreq_id  = tbl[i].id;
      stallreq_exe = tbl[i].exe;
      stallreq_mem = tbl[i].mem;
      sample();
      check($sformatf("merge_%0d_stall", i), stall, tbl[i].exp_stall);
      check($sformatf("merge_%0d_busy", i), busy, 1'b0);
      tick();
    end
    clear_inputs();
    tick();

    // ---- exception, no MEM stall ----
    excp_req    = 1'b1;
    excp_vector = 32'hBFC0_0380;
    sample();
    check("excp_idle_stall", stall, 6'b001111);
    check("excp_idle_flush", flush, 1'b0);
    tick();                            // FLUSH
    excp_vector  = 32'hDEAD_BEEF;      // must not affect flush_pc
    stallreq_id  = 1'b1;
    stallreq_exe = 1'b1;
    sample();
    check("excp_flush", flush, 1'b1);
    check("excp_flush_pc", flush_pc, 32'hBFC0_0380);
    check("excp_flush_stall", stall, 6'b000000);
    check("excp_flush_busy", busy, 1'b1);
    tick();                            // REFILL, second excp_req is ignored
    sample();
    check("refill_masked_stall", stall, 6'b000000);
    check("refill_flush", flush, 1'b0);
    check("refill_busy", busy, 1'b1);
    tick();                            // IDLE
    clear_inputs();
    sample();
    check("excp_idle_again_busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      sample();
      check($sformatf("no_second_flush_%0d", i), flush, 1'b0);
    end
    tick();

    // ---- exception while MEM stall held for 3 cycles ----
    excp_req     = 1'b1;
    excp_vector  = 32'h8000_0180;
    stallreq_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check($sformatf("memwait_%0d_stall", i), stall, 6'b011111);
      check($sformatf("memwait_%0d_flush", i), flush, 1'b0);
      tick();
    end
    stallreq_mem = 1'b0;
    stallreq_id  = 1'b1;               // ignored in WAIT_MEM
    sample();
    check("memwait_drop_stall", stall, 6'b001111);
    check("memwait_drop_flush", flush, 1'b0);
    check("memwait_drop_busy", busy, 1'b1);
    tick();                            // FLUSH
    stallreq_mem = 1'b1;               // FLUSH ignores every request
    sample();
    check("memwait_flush", flush, 1'b1);
    check("memwait_flush_pc", flush_pc, 32'h8000_0180);
    check("memwait_flush_stall", stall, 6'b000000);
    tick();                            // REFILL
    excp_req = 1'b0;
    sample();
    check("memwait_refill_mem_stall", stall, 6'b011111);
    tick();                            // IDLE
    clear_inputs();
    sample();
    check("memwait_done_busy", busy, 1'b0);
    check("memwait_done_stall", stall, 6'b000000);
    tick();

    // ---- reset asserted during WAIT_MEM aborts the flush ----
    excp_req     = 1'b1;
    excp_vector  = 32'hAAAA_5555;
    stallreq_mem = 1'b1;
    tick();                            // WAIT_MEM
    sample();
    check("abort_wait_busy", busy, 1'b1);
    check("abort_wait_stall", stall, 6'b011111);
    #2;
    reset = 1'b1;
    #1;
    check("abort_stall", stall, 6'b000000);
    check("abort_busy", busy, 1'b0);
    check("abort_flush", flush, 1'b0);
    check("abort_flush_pc", flush_pc, 32'h0);
    tick();
    clear_inputs();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      check($sformatf("abort_post_flush_%0d", i), flush, 1'b0);
      check($sformatf("abort_post_busy_%0d", i), busy, 1'b0);
      tick();
    end

    // ---- performance counters ----
    do_reset();
    do_excp(32'h0000_1000);            // 1 stall cycle (EXE in IDLE)
    do_excp(32'h0000_2000);            // 1 stall cycle
    stallreq_id = 1'b1;
    tick();
    tick();
    tick();                            // 3 stall cycles
    stallreq_id = 1'b0;
    sample();
`ifdef PIPE_CTRL_PERF_EN
    check("perf_stall_cycles", stall_cycles, 4'd5);
    check("perf_flush_count", flush_count, 4'd2);
`else
    check("perf_off_stall_cycles", stall_cycles, 4'd0);
    check("perf_off_flush_count", flush_count, 4'd0);
`endif
    tick();
    stallreq_id = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    stallreq_id = 1'b0;
    for (int i = 0; i < 14; i++) do_excp(32'h0000_3000);
    sample();
`ifdef PIPE_CTRL_PERF_EN
    check("perf_stall_sat", stall_cycles, 4'hF);
    check("perf_flush_sat", flush_count, 4'hF);
`else
    check("perf_off_stall_late", stall_cycles, 4'd0);
    check("perf_off_flush_late", flush_count, 4'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
